// File: rtl/ifetch_prefetch.sv
// Instruction prefetch queue: Wishbone slave towards the CPU instruction bus,
// Wishbone master towards instruction memory, refilling sequential words ahead of use.
module ifetch_prefetch #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        cpu_cyc_i,
    input  logic        cpu_stb_i,
    input  logic [31:0] cpu_adr_i,
    output logic [31:0] cpu_dat_o,
    output logic        cpu_ack_o,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic [31:0] mem_adr_o,
    output logic [3:0]  mem_sel_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_dat_i,
    input  logic        mem_ack_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [31:0]       r_fifo [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_head_adr;
    logic [31:0]       r_fetch_adr;
    logic [31:0]       r_mem_adr;
    logic [31:0]       r_cpu_dat;
    logic              r_cpu_ack;
    logic              r_base_valid;

    logic              w_req;
    logic              w_hit;
    logic              w_wait;
    logic              w_miss;
    logic              w_kill;
    logic              w_push;
    logic              w_launch;
    logic [31:0]       w_miss_adr;
    logic [31:0]       w_launch_adr;
    logic [1:0]        w_adr_unused;

    assign w_adr_unused = cpu_adr_i[1:0];
    assign w_miss_adr   = {cpu_adr_i[31:2], 2'b00};

    // A request is only looked at while no ack is showing, so acks never repeat back to back.
    assign w_req  = cpu_cyc_i & cpu_stb_i & ~r_cpu_ack;
    assign w_hit  = w_req & ~flush_i & (r_count != '0)
                  & (cpu_adr_i[31:2] == r_head_adr[31:2]);
    assign w_wait = w_req & (r_count == '0) & r_base_valid
                  & (cpu_adr_i[31:2] == r_fetch_adr[31:2]);
    assign w_miss = w_req & ~flush_i & ~w_hit & ~w_wait;
    assign w_kill = w_miss | flush_i;
    assign w_push = (r_state == FETCH) & mem_ack_i & ~w_kill;

    // A miss from IDLE goes straight to the bus at the new target instead of the stale fetch_adr.
    assign w_launch_adr = w_miss ? w_miss_adr : r_fetch_adr;

    // NOTE: async reset on the state register so the bus strobe drops the moment reset asserts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_miss || (r_base_valid && !flush_i && (r_count < FULL_C))) begin
                    w_launch    = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (mem_ack_i) begin
                    w_state_nxt = IDLE;
                end else if (w_kill) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_stb_o = (r_state != IDLE);
        mem_cyc_o = (r_state != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_head_adr   <= '0;
            r_fetch_adr  <= '0;
            r_mem_adr    <= '0;
            r_cpu_dat    <= '0;
            r_cpu_ack    <= 1'b0;
            r_base_valid <= 1'b0;
        end else begin
            r_cpu_ack <= w_hit;
            if (w_hit) begin
                r_cpu_dat  <= r_fifo[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                r_head_adr <= r_head_adr + 32'd4;
            end
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
                r_fetch_adr <= r_fetch_adr + 32'd4;
            end
            if (w_launch) begin
                r_mem_adr <= w_launch_adr;
            end
            if (w_kill) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_hit);
            end
            if (flush_i) begin
                r_base_valid <= 1'b0;
            end else if (w_miss) begin
                r_base_valid <= 1'b1;
                r_head_adr   <= w_miss_adr;
                r_fetch_adr  <= w_miss_adr;
            end
        end
    end

    // NOTE: queue storage has no reset; r_count alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= mem_dat_i;
        end
    end

    assign cpu_ack_o = r_cpu_ack;
    assign cpu_dat_o = r_cpu_dat;
    assign mem_adr_o = r_mem_adr;
    assign mem_sel_o = 4'hf;
    assign mem_we_o  = 1'b0;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized fetch streams.
module tb_ifetch_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        cpu_cyc_i = 1'b0;
    logic        cpu_stb_i = 1'b0;
    logic [31:0] cpu_adr_i = '0;
    logic [31:0] cpu_dat_o;
    logic        cpu_ack_o;
    logic        mem_cyc_o;
    logic        mem_stb_o;
    logic [31:0] mem_adr_o;
    logic [3:0]  mem_sel_o;
    logic        mem_we_o;
    logic [31:0] mem_dat_i;
    logic        mem_ack_i;

    int n_cmp = 0;
    int n_err = 0;
    int lat = 0;
    int wcnt = 0;
    bit rnd_flush = 0;
    logic [31:0] mem_log[$];

    ifetch_prefetch #(.DEPTH(DEPTH)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .cpu_cyc_i (cpu_cyc_i),
        .cpu_stb_i (cpu_stb_i),
        .cpu_adr_i (cpu_adr_i),
        .cpu_dat_o (cpu_dat_o),
        .cpu_ack_o (cpu_ack_o),
        .mem_cyc_o (mem_cyc_o),
        .mem_stb_o (mem_stb_o),
        .mem_adr_o (mem_adr_o),
        .mem_sel_o (mem_sel_o),
        .mem_we_o  (mem_we_o),
        .mem_dat_i (mem_dat_i),
        .mem_ack_i (mem_ack_i)
    );

    always #5 clk = ~clk;

    // Memory returns its own address as data; ack after lat wait cycles (0 = same cycle).
    assign mem_ack_i = mem_stb_o && (wcnt >= lat);
    assign mem_dat_i = mem_adr_o;

    always @(posedge clk) begin
        if (rst_i) wcnt <= 0;
        else if (mem_stb_o && !mem_ack_i) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i < mem_log.size()) ? mem_log[i] : 32'hDEAD_BEEF;
    endfunction

    // Reference model: queue of buffered words plus one optional outstanding bus transfer.
    logic [31:0] m_q[$];
    logic [31:0] m_head = '0, m_fetch = '0, m_adr = '0, m_dat = '0;
    bit m_bv = 0, m_busy = 0, m_doomed = 0, m_ack = 0;

    task automatic model_step();
        bit req, hit, wt, miss, ack_now;
        int n_old;
        logic [31:0] tgt;
        n_old   = m_q.size();
        tgt     = {cpu_adr_i[31:2], 2'b00};
        req     = cpu_cyc_i && cpu_stb_i && !m_ack;
        hit     = req && !flush_i && (n_old > 0) && (tgt == m_head);
        wt      = req && (n_old == 0) && m_bv && (tgt == m_fetch);
        miss    = req && !flush_i && !hit && !wt;
        ack_now = m_busy && mem_ack_i;
        m_ack = hit;
        if (hit) begin
            m_dat  = m_q.pop_front();
            m_head = m_head + 32'd4;
        end
        if (ack_now && !m_doomed && !miss && !flush_i) begin
            m_q.push_back(m_adr);
            m_fetch = m_fetch + 32'd4;
        end
        if (flush_i) begin
            m_q.delete();
            m_bv = 0;
        end
        if (miss) begin
            m_q.delete();
            m_head  = tgt;
            m_fetch = tgt;
            m_bv    = 1;
        end
        if (m_busy) begin
            if (ack_now) begin
                m_busy   = 0;
                m_doomed = 0;
            end else if (miss || flush_i) begin
                m_doomed = 1;
            end
        end else if (miss) begin
            m_busy = 1;
            m_adr  = tgt;
        end else if (!flush_i && m_bv && n_old < DEPTH) begin
            m_busy = 1;
            m_adr  = m_fetch;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst_i) begin
            m_q.delete();
            m_head = '0; m_fetch = '0; m_adr = '0; m_dat = '0;
            m_bv = 0; m_busy = 0; m_doomed = 0; m_ack = 0;
        end else begin
            if (mem_stb_o && mem_ack_i) mem_log.push_back(mem_adr_o);
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_i) begin
            check("cpu_ack", cpu_ack_o, m_ack);
            check("cpu_dat", cpu_dat_o, m_dat);
            check("mem_stb", mem_stb_o, m_busy);
            check("mem_cyc", mem_cyc_o, m_busy);
            if (m_busy) check("mem_adr", mem_adr_o, m_adr);
            check("mem_sel", mem_sel_o, 4'hf);
            check("mem_we", mem_we_o, 1'b0);
        end
    end

    // Starts a request on the next falling edge and holds it until acked; n counts cycles to ack.
    task automatic cpu_read(input logic [31:0] adr, output logic [31:0] dat, output int n);
        @(negedge clk);
        cpu_cyc_i = 1'b1;
        cpu_stb_i = 1'b1;
        cpu_adr_i = adr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            flush_i = rnd_flush && ($urandom_range(0, 15) == 0) && !cpu_ack_o;
        end while (!cpu_ack_o && n < 300);
        flush_i = 1'b0;
        if (!cpu_ack_o) check("ack_timeout", cpu_ack_o, 1'b1);
        dat = cpu_dat_o;
        cpu_cyc_i = 1'b0;
        cpu_stb_i = 1'b0;
    endtask

    initial begin
        logic [31:0] d, adr;
        int n, r;

        repeat (3) @(negedge clk);
        check("rst_ack", cpu_ack_o, 1'b0);
        check("rst_dat", cpu_dat_o, 32'h0);
        check("rst_stb", mem_stb_o, 1'b0);
        check("rst_cyc", mem_cyc_o, 1'b0);
        check("rst_adr", mem_adr_o, 32'h0);
        rst_i = 1'b0;

        lat = 0;
        mem_log.delete();
        cpu_read(32'h7000_0000, d, n);
        check("first_lat", n, 3);
        check("first_dat", d, 32'h7000_0000);
        repeat (15) @(negedge clk);
        check("fill_count", mem_log.size(), 5);
        for (int i = 0; i < 5; i++) check("fill_adr", log_at(i), 32'h7000_0000 + 32'(4 * i));

        mem_log.delete();
        cpu_read(32'h7000_0100, d, n);
        check("branch_lat", n, 3);
        check("branch_dat", d, 32'h7000_0100);
        check("branch_adr", log_at(0), 32'h7000_0100);

        repeat (12) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            cpu_read(32'h7000_0100 + 32'(4 * i), d, n);
            check("seq_lat", n, 1);
            check("seq_dat", d, 32'h7000_0100 + 32'(4 * i));
        end

        lat = 3;
        repeat (30) @(negedge clk);
        mem_log.delete();
        cpu_read(32'h7000_2000, d, n);
        check("slow_dat", d, 32'h7000_2000);
        cpu_read(32'h7000_3000, d, n);
        check("drain_lat", n, 9);
        check("drain_dat", d, 32'h7000_3000);
        check("drain_old", log_at(1), 32'h7000_2004);
        check("drain_new", log_at(2), 32'h7000_3000);

        lat = 0;
        repeat (30) @(negedge clk);
        mem_log.delete();
        cpu_read(32'hFFFF_FFF8, d, n);
        check("wrap_dat0", d, 32'hFFFF_FFF8);
        cpu_read(32'hFFFF_FFFC, d, n);
        check("wrap_dat1", d, 32'hFFFF_FFFC);
        cpu_read(32'h0000_0000, d, n);
        check("wrap_dat2", d, 32'h0000_0000);
        cpu_read(32'h0000_0004, d, n);
        check("wrap_dat3", d, 32'h0000_0004);
        check("wrap_adr0", log_at(0), 32'hFFFF_FFF8);
        check("wrap_adr1", log_at(1), 32'hFFFF_FFFC);
        check("wrap_adr2", log_at(2), 32'h0000_0000);
        check("wrap_adr3", log_at(3), 32'h0000_0004);

        repeat (20) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        mem_log.delete();
        repeat (10) @(negedge clk);
        check("flush_quiet", mem_log.size(), 0);
        check("flush_stb", mem_stb_o, 1'b0);
        cpu_read(32'h0000_0008, d, n);
        check("flush_lat", n, 3);
        check("flush_dat", d, 32'h0000_0008);

        rnd_flush = 1;
        adr = 32'h4000_0000;
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(0, 3);
            r = $urandom_range(0, 99);
            if (r < 70) adr = {adr[31:2], 2'b00} + 32'd4;
            else if (r < 80) adr = adr;
            else if (r < 90) adr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else adr = $urandom();
            cpu_read(adr, d, n);
            check("rnd_dat", d, {adr[31:2], 2'b00});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rnd_flush = 0;

        lat = 3;
        repeat (40) @(negedge clk);
        cpu_cyc_i = 1'b1;
        cpu_stb_i = 1'b1;
        cpu_adr_i = 32'h7000_4000;
        @(negedge clk);
        check("midrst_pre", mem_stb_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        check("midrst_cyc", mem_cyc_o, 1'b0);
        check("midrst_stb", mem_stb_o, 1'b0);
        cpu_cyc_i = 1'b0;
        cpu_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        cpu_read(32'h7000_5000, d, n);
        check("post_rst_dat", d, 32'h7000_5000);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
